// File: rtl/am_guard_pkg.sv
// Shared state encoding and gain-target helper for the AM output guard.
package am_guard_pkg;

    typedef enum logic [1:0] {
        ST_MUTED    = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_RUN      = 2'd2,
        ST_FADE_OUT = 2'd3
    } guard_state_e;

    // Attenuated target is half scale, snapped down onto the step grid so ramps land on it exactly.
    function automatic int unsigned gain_target(input logic        atten,
                                                input int unsigned gain_max,
                                                input int unsigned gain_step);
        if (atten) begin
            return ((gain_max / 2) / gain_step) * gain_step;
        end
        return gain_max;
    endfunction

endpackage

// File: rtl/am_gain_scaler.sv
// Registered signed sample scaler: m_data = floor(s_data * gain / 2**GAIN_W), exact at unity and zero gain.
module am_gain_scaler #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic        [GAIN_W-1:0] gain,
    output logic                     m_valid,
    output logic signed [DATA_W-1:0] m_data
);

    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam logic [GAIN_W-1:0] GAIN_FULL = '1;

    logic signed [PROD_W-1:0] product;
    logic                     unused_prod_hi;
    logic        [GAIN_W-1:0] unused_prod_lo;
    logic signed [DATA_W-1:0] scaled;

    logic                     m_valid_d, m_valid_q;
    logic signed [DATA_W-1:0] m_data_d,  m_data_q;

    // Gain is unsigned; the zero-extended operand keeps the multiply signed without flipping large gains negative.
    assign product = $signed(PROD_W'(s_data)) * $signed(PROD_W'({1'b0, gain}));
    assign {unused_prod_hi, scaled, unused_prod_lo} = product;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        m_valid_d = s_valid;
        m_data_d  = m_data_q;
        if (s_valid) begin
            if (gain == '0) begin
                m_data_d = '0;
            end else if (gain == GAIN_FULL) begin
                m_data_d = s_data;
            end else begin
                m_data_d = scaled;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: rtl/am_output_guard.sv
// Watchdog-driven click-free mute/fade of the AM sample stream ahead of the DAC.
// Optional WARN_ATTEN_EN: in RUN, watchdog warning steps gain down to about half scale.
module am_output_guard
    import am_guard_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_STEP = 51,
    parameter int TICK_DIV  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     wd_triggered,
    input  logic                     wd_warning,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    output logic signed [DATA_W-1:0] m_data,
    output logic        [GAIN_W-1:0] gain,
    output logic                     muted,
    output logic        [1:0]        state
);

    localparam int GAIN_MAX = 2**GAIN_W - 1;
    localparam int TICK_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] GAIN_INC  = GAIN_W'(GAIN_STEP);

    if (GAIN_STEP < 1 || GAIN_STEP > GAIN_MAX) begin : g_bad_step_range
        $error("am_output_guard: GAIN_STEP out of range");
    end else if ((GAIN_MAX % GAIN_STEP) != 0) begin : g_bad_step_grid
        $error("am_output_guard: GAIN_MAX must be a multiple of GAIN_STEP");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("am_output_guard: TICK_DIV must be at least 2");
    end

    guard_state_e      state_d, state_q;
    logic [GAIN_W-1:0] gain_d,  gain_q;
    logic [TICK_W-1:0] tick_d,  tick_q;

    logic              stop;
    logic              tick_end;
    logic [GAIN_W:0]   gain_up;

    assign stop     = wd_triggered | ~enable;
    assign tick_end = (tick_q == TICK_LAST);
    assign gain_up  = {1'b0, gain_q} + {1'b0, GAIN_INC};

`ifdef WARN_ATTEN_EN
    logic [GAIN_W-1:0] target;
    assign target = GAIN_W'(gain_target(wd_warning & ~wd_triggered,
                                        int'(GAIN_MAX), int'(GAIN_STEP)));
`else
    logic unused_warning;
    assign unused_warning = wd_warning;
`endif

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        unique case (state_q)
            ST_MUTED: begin
                gain_d = '0;
                if (!stop) state_d = ST_FADE_IN;
            end
            ST_FADE_IN: begin
                if (stop) begin
                    state_d = ST_FADE_OUT;
                end else if (tick_end) begin
                    if (gain_up >= {1'b0, GAIN_FULL}) begin
                        gain_d  = GAIN_FULL;
                        state_d = ST_RUN;
                    end else begin
                        gain_d = gain_up[GAIN_W-1:0];
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_FADE_OUT;
                end else if (tick_end) begin
`ifdef WARN_ATTEN_EN
                    if (gain_q < target) begin
                        gain_d = (gain_up >= {1'b0, target}) ? target : gain_up[GAIN_W-1:0];
                    end else if (gain_q > target) begin
                        gain_d = ((gain_q - target) <= GAIN_INC) ? target : gain_q - GAIN_INC;
                    end
`else
                    gain_d = GAIN_FULL;
`endif
                end
            end
            ST_FADE_OUT: begin
                // Fade-out runs to completion regardless of stop, so the carrier never jumps.
                if (tick_end) begin
                    if (gain_q <= GAIN_INC) begin
                        gain_d  = '0;
                        state_d = ST_MUTED;
                    end else begin
                        gain_d = gain_q - GAIN_INC;
                    end
                end
            end
            default: state_d = ST_MUTED;
        endcase

        tick_d = (state_d != state_q || tick_end) ? '0 : tick_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_MUTED;
            gain_q  <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            tick_q  <= tick_d;
        end
    end

    am_gain_scaler #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W)
    ) u_scaler (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .gain    (gain_q),
        .m_valid (m_valid),
        .m_data  (m_data)
    );

    assign gain  = gain_q;
    assign muted = (state_q == ST_MUTED);
    assign state = state_q;

endmodule

// File: tb/tb_am_output_guard.sv
// Directed bench for am_output_guard with TICK_DIV=4 (full fade = 20 clocks).
module tb_am_output_guard;

    localparam int DATA_W    = 16;
    localparam int GAIN_W    = 8;
    localparam int GAIN_STEP = 51;
    localparam int TICK_DIV  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic                     wd_triggered;
    logic                     wd_warning;
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     m_valid;
    logic signed [DATA_W-1:0] m_data;
    logic        [GAIN_W-1:0] gain;
    logic                     muted;
    logic        [1:0]        state;

    int n_checks = 0;
    int n_fail   = 0;

    am_output_guard #(
        .DATA_W    (DATA_W),
        .GAIN_W    (GAIN_W),
        .GAIN_STEP (GAIN_STEP),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .wd_triggered (wd_triggered),
        .wd_warning   (wd_warning),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .gain         (gain),
        .muted        (muted),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; wd_triggered = 1'b0; wd_warning = 1'b0;
        s_valid = 1'b0; s_data = '0;

        // Reset state
        cyc(2);
        check("rst_state", state, 0);
        check("rst_gain", gain, 0);
        check("rst_muted", muted, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);

        // Fade in: FADE_IN at clk 1, gain steps every 4 clocks, RUN at 255
        rst = 1'b0;
        cyc(1);
        check("fi_enter_state", state, 1);
        check("fi_enter_gain", gain, 0);
        cyc(3);
        check("fi_gain_before_tick", gain, 0);
        cyc(1);
        check("fi_gain_51", gain, 51);
        cyc(15);
        check("fi_gain_204", gain, 204);
        check("fi_state_204", state, 1);
        cyc(1);
        check("run_gain", gain, 255);
        check("run_state", state, 2);

        // Watchdog warning in RUN
        wd_warning = 1'b1;
        cyc(4);
`ifdef WARN_ATTEN_EN
        check("warn_gain_204", gain, 204);
`else
        check("warn_gain_ignored", gain, 255);
`endif
        cyc(12);
`ifdef WARN_ATTEN_EN
        check("warn_gain_hold", gain, 102);
`else
        check("warn_gain_hold", gain, 255);
`endif
        check("warn_state_run", state, 2);
        wd_warning = 1'b0;
        cyc(12);
        check("warn_clear_gain", gain, 255);
        check("warn_clear_state", state, 2);

        // Unity-gain datapath
        s_valid = 1'b1; s_data = 16'sd1000;
        cyc(1);
        check("dp_1000_valid", m_valid, 1);
        check("dp_1000_data", m_data, 1000);
        s_data = 16'sh7FFF;
        cyc(1);
        check("dp_max_data", m_data, 32767);
        s_data = -16'sd1000;
        cyc(1);
        check("dp_neg_unity", m_data, -1000);
        s_valid = 1'b0;
        cyc(1);
        check("dp_valid_drop", m_valid, 0);

        // Watchdog trip; release at gain 153, fade must still complete
        wd_triggered = 1'b1;
        cyc(1);
        check("fo_state", state, 3);
        check("fo_gain_entry", gain, 255);
        cyc(4);
        check("fo_gain_204", gain, 204);
        cyc(4);
        check("fo_gain_153", gain, 153);
        wd_triggered = 1'b0;
        cyc(4);
        check("fo_gain_102", gain, 102);
        check("fo_state_continues", state, 3);
        s_valid = 1'b1; s_data = -16'sd1000;
        cyc(1);
        check("dp_102_valid", m_valid, 1);
        check("dp_102_floor", m_data, -399);
        s_valid = 1'b0;
        cyc(6);
        check("fo_gain_51", gain, 51);
        check("fo_state_51", state, 3);
        cyc(1);
        check("fo_muted_state", state, 0);
        check("fo_muted_gain", gain, 0);
        check("fo_muted_flag", muted, 1);
        cyc(1);
        check("refade_state", state, 1);

        // enable drop mid FADE_IN (tick mid-count) at gain 102
        cyc(8);
        check("fi2_gain_102", gain, 102);
        cyc(2);
        enable = 1'b0;
        cyc(1);
        check("en_fo_state", state, 3);
        check("en_fo_gain", gain, 102);
        cyc(3);
        check("en_tick_cleared", gain, 102);
        cyc(1);
        check("en_gain_51", gain, 51);
        cyc(3);
        check("en_state_51", state, 3);
        cyc(1);
        check("en_muted_state", state, 0);
        check("en_muted_gain", gain, 0);

        // MUTED keeps the DAC cadence with zero data
        s_valid = 1'b1; s_data = 16'sd1234;
        cyc(1);
        check("mute_valid_1", m_valid, 1);
        check("mute_data_1", m_data, 0);
        s_valid = 1'b0;
        cyc(1);
        check("mute_valid_0", m_valid, 0);
        s_valid = 1'b1; s_data = -16'sd5;
        cyc(1);
        check("mute_valid_2", m_valid, 1);
        check("mute_data_2", m_data, 0);
        s_valid = 1'b0;
        cyc(5);
        check("mute_hold_state", state, 0);

        // Re-enable, then scale at gain 51
        enable = 1'b1;
        cyc(1);
        check("reen_state", state, 1);
        cyc(4);
        check("reen_gain_51", gain, 51);
        s_valid = 1'b1; s_data = -16'sd1000;
        cyc(1);
        check("dp_51_valid", m_valid, 1);
        check("dp_51_floor", m_data, -200);

        // Asynchronous reset mid-fade drops the pending sample
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_gain", gain, 0);
        check("arst_m_valid", m_valid, 0);
        check("arst_muted", muted, 1);
        s_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
